// File: rtl/switch_encoder_if.sv
// Switch bank bus: raw switch levels in, encoded position and flags out.
// The encoder takes the slave side; whoever owns the switches and consumes
// the encoded result takes the master side.
interface switch_encoder_if;
  logic [0:15] i_Switch;
  logic [3:0]  o_Value;
  logic        o_Valid;
  logic        o_Multi;
  logic        o_Change;

  modport master (
    output i_Switch,
    input  o_Value,
    input  o_Valid,
    input  o_Multi,
    input  o_Change
  );

  modport slave (
    input  i_Switch,
    output o_Value,
    output o_Valid,
    output o_Multi,
    output o_Change
  );
endinterface

// File: rtl/switch_encoder.sv
// 16-position switch bank encoder: two-flop synchroniser, debounce FSM and a
// priority encoder whose result is registered only when a debounced vector is
// accepted. o_Change pulses for one cycle when {o_Valid, o_Value} moves.
module switch_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_WIDTH       = 20
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  switch_encoder_if.slave  bus
);

  typedef enum logic [0:0] {
    S_STABLE = 1'b0,
    S_SETTLE = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  // Index of the highest-numbered set bit; 0 for an empty vector.
  function automatic logic [3:0] f_hi_index(input logic [0:15] vec);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (vec[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

  // True when two or more bits of the vector are set.
  function automatic logic f_multi(input logic [0:15] vec);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'd0, vec[i]};
    end
    return (cnt >= 5'd2);
  endfunction

  logic [0:15]          sync1_q;
  logic [0:15]          sync2_q;
  logic [0:15]          cand_q;
  logic [0:15]          stable_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  state_t               state_q;
  logic [3:0]           value_q;
  logic                 valid_q;
  logic                 multi_q;
  logic                 change_q;

  logic [3:0]           value_d;
  logic                 valid_d;
  logic                 multi_d;

  // Encode the candidate so the result is ready to register at the accept edge.
  always_comb begin
    value_d = f_hi_index(cand_q);
    valid_d = |cand_q;
    multi_d = f_multi(cand_q);
  end

  // Synchroniser, debounce FSM and registered encoder outputs.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      sync1_q  <= 16'h0000;
      sync2_q  <= 16'h0000;
      cand_q   <= 16'h0000;
      stable_q <= 16'h0000;
      cnt_q    <= '0;
      state_q  <= S_STABLE;
      value_q  <= 4'd0;
      valid_q  <= 1'b0;
      multi_q  <= 1'b0;
      change_q <= 1'b0;
    end else begin
      sync1_q  <= bus.i_Switch;
      sync2_q  <= sync1_q;
      change_q <= 1'b0;
      case (state_q)
        S_STABLE: begin
          if (sync2_q != stable_q) begin
            cand_q  <= sync2_q;
            cnt_q   <= '0;
            state_q <= S_SETTLE;
          end else begin
            cnt_q   <= '0;
          end
        end
        S_SETTLE: begin
          if (sync2_q != cand_q) begin
            // Bounce: restart the settle window on the new level.
            cand_q <= sync2_q;
            cnt_q  <= '0;
          end else if (cnt_q == CNT_LAST) begin
            stable_q <= cand_q;
            value_q  <= value_d;
            valid_q  <= valid_d;
            multi_q  <= multi_d;
            // Only the position/valid pair drives the strobe; o_Multi alone does not.
            change_q <= ({valid_d, value_d} != {valid_q, value_q});
            state_q  <= S_STABLE;
          end else begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
          end
        end
        default: begin
          state_q <= S_STABLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.o_Value  = value_q;
  assign bus.o_Valid  = valid_q;
  assign bus.o_Multi  = multi_q;
  assign bus.o_Change = change_q;

endmodule

// File: doc/switch_encoder.md
Name: switch_encoder

Overview:
- Input-side counterpart of the one-hot LED decoder: reads a 16-position switch bank and encodes it into a 4-bit value.
- Synchronises and debounces the 16 raw switch inputs, then priority-encodes the accepted vector into a 4-bit index.
- Flags whether any switch is on and whether more than one is on.
- Emits a one-cycle change strobe so downstream logic (servo position select, LED display) updates only on a debounced edit.

Parameters:
- DEBOUNCE_CYCLES, 1000000, clock cycles the synchronised vector must hold steady before acceptance (10 ms at 100 MHz); legal range 1 to 2^CNT_WIDTH-1.
- CNT_WIDTH, 20, width of the debounce counter.

Ports:
- i_Clk  input  1  system clock; all logic on rising edge.
- i_Rst_n  input  1  synchronous, active-low reset, sampled on rising edge of i_Clk.
- i_Switch  input  [0:15]  raw asynchronous switch levels, bit n = position n (same ordering as the LED bank).
- o_Value  output  [3:0]  index of the highest-numbered on switch in the accepted vector; 0 when none on.
- o_Valid  output  1  1 when at least one accepted switch is on.
- o_Multi  output  1  1 when two or more accepted switches are on.
- o_Change  output  1  one-cycle pulse when {o_Valid, o_Value} changes.

Behaviour:
- Reset (i_Rst_n=0 at an edge):
  - Sync flops, candidate vector, stable vector and counter go to 0; state goes to S_STABLE.
  - o_Value=0, o_Valid=0, o_Multi=0, o_Change=0.
  - Reset dominates all other activity, including mid-settle; any pending candidate is discarded.
- Synchroniser: two-flop chain sync1 <= i_Switch, sync2 <= sync1. Only sync2 is used downstream.
- S_STABLE:
  - If sync2 == stable vector: stay, counter held at 0.
  - If sync2 != stable vector: candidate <= sync2, counter <= 0, go to S_SETTLE.
- S_SETTLE:
  - If sync2 != candidate (bounce): candidate <= sync2, counter <= 0, stay.
  - Else if counter == DEBOUNCE_CYCLES-1 (accept): stable vector <= candidate, outputs updated, go to S_STABLE.
  - Else: counter <= counter+1.
- A bounce back to the original stable vector still completes a full settle. On acceptance no output changes and o_Change stays 0.
- Encoding, computed from the candidate and registered at the accept edge:
  - o_Value = highest set index (bit 15 has top priority).
  - o_Valid = OR of all 16 bits.
  - o_Multi = 1 if popcount >= 2.
  - All-zero vector gives o_Value=0, o_Valid=0, o_Multi=0.
  - Switch 0 alone gives o_Value=0 with o_Valid=1; the bench must distinguish this from the all-zero case.
- o_Change: 1 for exactly the cycle after an accept edge where the new {o_Valid, o_Value} differs from the previous value, else 0.
  - A change only in o_Multi (e.g. adding a lower switch under a higher one) does not pulse o_Change.
- Latency: a new i_Switch level held steady from edge k onward is reflected on outputs after edge k+DEBOUNCE_CYCLES+2, i.e. DEBOUNCE_CYCLES+3 edges counting edge k.
- Counter never wraps; it is bounded by the accept compare.
- Outputs are fully registered; no combinational path from i_Switch to any output.

Test Plan (DEBOUNCE_CYCLES=4 for simulation):
1. Reset: hold i_Rst_n=0 for 3 cycles with i_Switch=16'hFFFF -> all outputs 0 throughout. After release with the input steady -> o_Value=15, o_Valid=1, o_Multi=1, o_Change=1 for one cycle, 7 edges after release.
2. Single switch: from all-off, set only bit 5 and hold -> after 7 edges o_Value=5, o_Valid=1, o_Multi=0, one-cycle o_Change. Holding further produces no additional o_Change.
3. Bounce: toggle bit 9 on/off every 2 cycles for 10 cycles, then hold on -> no output change during toggling. Outputs o_Value=9 exactly 7 edges after the last toggle.
4. Priority and multi:
   - Bits 3 and 12 on -> o_Value=12, o_Multi=1.
   - Then clear bit 12 -> o_Value=3, o_Multi=0, o_Change pulse.
   - Then add bit 1 -> o_Multi=1, o_Value stays 3, no o_Change.
5. Zero versus switch 0:
   - Bit 0 only -> o_Value=0, o_Valid=1, o_Change pulse.
   - Clear all -> o_Value=0, o_Valid=0, o_Change pulse.
6. Reset mid-settle: change the input to bit 7, then assert i_Rst_n=0 at edge 4 of settling -> outputs stay 0 and the state returns to S_STABLE. After release, a full 7-edge latency gives o_Value=7.
